// File: rtl/sumador_pkg.sv
// Shared types and helpers for the digit-serial adder/subtractor.
package sumador_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    HOLD = 2'd2
  } state_e;

  localparam logic MODO_SUMA  = 1'b0;
  localparam logic MODO_RESTA = 1'b1;

  // Width needed to count 0..value-1; never returns less than 1.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < value) r++;
    if (r == 0) r = 1;
    return r;
  endfunction

endpackage

// File: rtl/sumador_serie_param_if.sv
// Operand/result handshake bundle for sumador_serie_param.
interface sumador_serie_param_if
  import sumador_pkg::*;
#(
  parameter int unsigned WIDTH = 8
);
  logic             valid_in;
  logic             ready_in;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Cin;
  logic             resta;
  logic             valid_out;
  logic             ready_out;
  logic [WIDTH-1:0] S;
  logic             Cout;
  logic             V;

  modport master (
    output valid_in, A, B, Cin, resta, ready_out,
    input  ready_in, valid_out, S, Cout, V
  );

  modport slave (
    input  valid_in, A, B, Cin, resta, ready_out,
    output ready_in, valid_out, S, Cout, V
  );
endinterface

// File: rtl/sumador_digito.sv
// Combinational DIGIT-bit ripple-carry slice; also exposes the carry into its top bit.
module sumador_digito
  import sumador_pkg::*;
#(
  parameter int unsigned DIGIT = 2
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             cin,
  output logic [DIGIT-1:0] sum,
  output logic             cout,
  output logic             c_top
);
  logic [DIGIT:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < DIGIT; i++) begin : g_fa
    assign sum[i]  = a[i] ^ b[i] ^ c[i];
    assign c[i+1]  = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign cout  = c[DIGIT];
  assign c_top = c[DIGIT-1];
endmodule

// File: rtl/sumador_serie_param.sv
// Digit-serial adder/subtractor with valid/ready handshake, LSD first.
// Define SUMADOR_SATURACION_EN to saturate S to the signed limit on overflow.
module sumador_serie_param
  import sumador_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIGIT = 2
) (
  input logic                 clk,
  input logic                 rst,
  sumador_serie_param_if.slave bus
);
  localparam int unsigned N    = WIDTH / DIGIT;
  localparam int unsigned CntW = clog2(N);
  localparam logic [CntW-1:0] LastCnt = CntW'(N - 1);

  if (WIDTH < 2 || DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_param_err
    $error("sumador_serie_param: invalid WIDTH/DIGIT combination");
  end

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             v_q, v_d;

  logic [DIGIT-1:0]       dig_sum;
  logic                   dig_cout;
  logic                   dig_ctop;
  logic [WIDTH+DIGIT-1:0] s_cat;

  sumador_digito #(
    .DIGIT(DIGIT)
  ) u_digito (
    .a    (a_q[DIGIT-1:0]),
    .b    (b_q[DIGIT-1:0]),
    .cin  (carry_q),
    .sum  (dig_sum),
    .cout (dig_cout),
    .c_top(dig_ctop)
  );

  // New digit enters at the top; after N shifts the result is aligned.
  assign s_cat = {dig_sum, s_q};

`ifdef SUMADOR_SATURACION_EN
  logic msb_a_q, msb_a_d;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    s_d     = s_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    v_d     = v_q;
`ifdef SUMADOR_SATURACION_EN
    msb_a_d = msb_a_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (bus.valid_in) begin
          a_d     = bus.A;
          b_d     = (bus.resta == MODO_RESTA) ? ~bus.B : bus.B;
          carry_d = (bus.resta == MODO_RESTA) ? 1'b1 : bus.Cin;
          cnt_d   = '0;
          state_d = CALC;
`ifdef SUMADOR_SATURACION_EN
          msb_a_d = bus.A[WIDTH-1];
`endif
        end
      end
      CALC: begin
        a_d     = a_q >> DIGIT;
        b_d     = b_q >> DIGIT;
        s_d     = s_cat[WIDTH+DIGIT-1:DIGIT];
        carry_d = dig_cout;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LastCnt) begin
          cout_d  = dig_cout;
          v_d     = dig_ctop ^ dig_cout;
          state_d = HOLD;
`ifdef SUMADOR_SATURACION_EN
          // On overflow both operand MSBs agree, so A's MSB picks the limit.
          if (dig_ctop ^ dig_cout) begin
            s_d = msb_a_q ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
          end
`endif
        end
      end
      HOLD: begin
        if (bus.ready_out) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      v_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      s_q     <= s_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      v_q     <= v_d;
    end
  end

`ifdef SUMADOR_SATURACION_EN
  always_ff @(posedge clk) begin
    if (rst) msb_a_q <= 1'b0;
    else     msb_a_q <= msb_a_d;
  end
`endif

  assign bus.ready_in  = (state_q == IDLE);
  assign bus.valid_out = (state_q == HOLD);
  assign bus.S         = s_q;
  assign bus.Cout      = cout_q;
  assign bus.V         = v_q;
endmodule

// File: tb/tb_sumador_serie_param.sv
// Directed bench driving four instances (DIGIT = 1, 2, 4, 8) in lockstep, WIDTH = 8.
module tb_sumador_serie_param;
  import sumador_pkg::*;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       resta;
    logic [7:0] s_wrap;
    logic [7:0] s_sat;
    logic       cout;
    logic       v;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic valid_in = 1'b0;
  logic ready_out = 1'b0;
  logic [7:0] a_drv = '0;
  logic [7:0] b_drv = '0;
  logic cin_drv = 1'b0;
  logic resta_drv = 1'b0;

  wire [3:0]      rdy;
  wire [3:0]      vo;
  wire [3:0]      co;
  wire [3:0]      vv;
  wire [3:0][7:0] s_arr;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int unsigned D = 1 << g;
    sumador_serie_param_if #(.WIDTH(8)) bus_if ();

    assign bus_if.valid_in  = valid_in;
    assign bus_if.A         = a_drv;
    assign bus_if.B         = b_drv;
    assign bus_if.Cin       = cin_drv;
    assign bus_if.resta     = resta_drv;
    assign bus_if.ready_out = ready_out;
    assign rdy[g]   = bus_if.ready_in;
    assign vo[g]    = bus_if.valid_out;
    assign co[g]    = bus_if.Cout;
    assign vv[g]    = bus_if.V;
    assign s_arr[g] = bus_if.S;

    sumador_serie_param #(
      .WIDTH(8),
      .DIGIT(D)
    ) u_dut (
      .clk(clk),
      .rst(rst),
      .bus(bus_if.slave)
    );
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic run_op(input vec_t v, input int hold_cycles, input bit overlap);
    int         lat [4];
    logic [7:0] es;
    bit         done;
    es = v.s_wrap;
`ifdef SUMADOR_SATURACION_EN
    es = v.s_sat;
`endif
    for (int g = 0; g < 4; g++) lat[g] = 0;
    check_eq("pre_ready", 32'(rdy), 32'hF);
    a_drv     = v.a;
    b_drv     = v.b;
    cin_drv   = v.cin;
    resta_drv = v.resta;
    valid_in  = 1'b1;
    @(posedge clk); #1;
    valid_in  = 1'b0;
    a_drv     = 8'h5A;
    b_drv     = 8'hC3;
    done      = 1'b0;
    for (int k = 1; k <= 20 && !done; k++) begin
      @(posedge clk); #1;
      for (int g = 0; g < 4; g++) if (vo[g] && lat[g] == 0) lat[g] = k;
      if (&vo) done = 1'b1;
    end
    check_eq("latency", {8'(lat[3]), 8'(lat[2]), 8'(lat[1]), 8'(lat[0])},
             {8'd1, 8'd2, 8'd4, 8'd8});
    check_eq("result_s", s_arr, {4{es}});
    check_eq("result_cout", 32'(co), 32'({4{v.cout}}));
    check_eq("result_v", 32'(vv), 32'({4{v.v}}));
    for (int h = 0; h < hold_cycles; h++) begin
      @(posedge clk); #1;
      check_eq("bp_s", s_arr, {4{es}});
      check_eq("bp_flags", {vo, rdy, co, vv}, {4'hF, 4'h0, {4{v.cout}}, {4{v.v}}});
    end
    ready_out = 1'b1;
    if (overlap) begin
      a_drv    = 8'h11;
      b_drv    = 8'h22;
      valid_in = 1'b1;
    end
    @(posedge clk); #1;
    ready_out = 1'b0;
    valid_in  = 1'b0;
    check_eq("retire", {rdy, vo}, {4'hF, 4'h0});
  endtask

  vec_t vecs [9];
  logic seen_valid;

  initial begin
    //                a      b      cin   resta s_wrap s_sat cout  v
    vecs[0] = '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0};
    vecs[1] = '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 8'h7F, 1'b0, 1'b1};
    vecs[2] = '{8'h0F, 8'h01, 1'b1, 1'b0, 8'h11, 8'h11, 1'b0, 1'b0};
    vecs[3] = '{8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 8'hFE, 1'b0, 1'b0};
    vecs[4] = '{8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 8'h80, 1'b1, 1'b1};
    vecs[5] = '{8'h10, 8'h10, 1'b1, 1'b1, 8'h00, 8'h00, 1'b1, 1'b0};
    vecs[6] = '{8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 8'h80, 1'b1, 1'b1};
    vecs[7] = '{8'h3C, 8'h45, 1'b0, 1'b0, 8'h81, 8'h7F, 1'b0, 1'b1};
    vecs[8] = '{8'h12, 8'h34, 1'b1, 1'b0, 8'h47, 8'h47, 1'b0, 1'b0};

    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check_eq("reset_hs", {rdy, vo}, {4'hF, 4'h0});
    check_eq("reset_s", s_arr, 32'h0);
    check_eq("reset_flags", {co, vv}, 8'h00);

    run_op(vecs[0], 10, 1'b0);
    for (int i = 1; i < 9; i++) run_op(vecs[i], 0, (i == 2));

    // Abort an operation with reset during the second digit cycle.
    a_drv     = 8'h33;
    b_drv     = 8'h44;
    cin_drv   = 1'b0;
    resta_drv = 1'b0;
    valid_in  = 1'b1;
    @(posedge clk); #1;
    valid_in = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_eq("abort_hs", {rdy, vo}, {4'hF, 4'h0});
    check_eq("abort_s", s_arr, 32'h0);
    check_eq("abort_flags", {co, vv}, 8'h00);
    seen_valid = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      seen_valid = seen_valid | (|vo);
    end
    check_eq("abort_no_result", 32'(seen_valid), 32'h0);

    run_op(vecs[8], 3, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
